// File: rtl/draw_rect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : draw_rect                                                     |
// | Purpose  : Overlays a solid rectangle on a video pixel stream. The       |
// |            top-left corner (xpos, ypos) is sampled once per frame at     |
// |            the rising edge of vblnk_in, so moves never tear a frame.     |
// |            Fixed two-cycle latency on every output.                      |
// | Ports    : pclk, rst                    clock / sync active-high reset   |
// |            hcount_in, vcount_in [10:0]  pixel position from timing       |
// |            hsync_in, vsync_in           sync strobes                     |
// |            hblnk_in, vblnk_in           blanking strobes                 |
// |            rgb_in [11:0]                background pixel (4:4:4)         |
// |            xpos, ypos [11:0]            requested top-left corner        |
// |            *_out                        the above, delayed 2 cycles      |
// |            rgb_out [11:0]               composed pixel                   |
// | Options  : define DRAW_RECT_BORDER_EN to paint the rectangle's outer     |
// |            one-pixel edge in BORDER_COLOR.                               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module draw_rect #(
    parameter int          RECT_WIDTH   = 48,
    parameter int          RECT_HEIGHT  = 64,
    parameter logic [11:0] RECT_COLOR   = 12'hF00,
    parameter logic [11:0] BORDER_COLOR = 12'hFFF
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    localparam logic [12:0] c_RECT_W = 13'(RECT_WIDTH);
    localparam logic [12:0] c_RECT_H = 13'(RECT_HEIGHT);

    // ------------------------------------------------------------------
    // Frame-start detect and per-frame corner shadow registers
    // ------------------------------------------------------------------
    logic        r_vblnk_prev;
    logic [11:0] r_x_lat;
    logic [11:0] r_y_lat;
    logic        w_frame_start;

    assign w_frame_start = vblnk_in & ~r_vblnk_prev;

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_vblnk_prev <= 1'b0;
            r_x_lat      <= 12'd0;
            r_y_lat      <= 12'd0;
        end else begin
            r_vblnk_prev <= vblnk_in;
            if (w_frame_start) begin
                r_x_lat <= xpos;
                r_y_lat <= ypos;
            end
        end
    end

    // ------------------------------------------------------------------
    // Hit test. Everything is widened to 13 bits so that a corner near
    // the far edge plus the rectangle size can never wrap back to 0.
    // The compare uses the shadow registers as they stand this cycle,
    // so a pixel coinciding with frame_start still sees the old corner.
    // ------------------------------------------------------------------
    logic [12:0] w_h;
    logic [12:0] w_v;
    logic [12:0] w_x;
    logic [12:0] w_y;
    logic [12:0] w_x_end;
    logic [12:0] w_y_end;
    logic        w_h_hit;
    logic        w_v_hit;

    assign w_h     = {2'b00, hcount_in};
    assign w_v     = {2'b00, vcount_in};
    assign w_x     = {1'b0, r_x_lat};
    assign w_y     = {1'b0, r_y_lat};
    assign w_x_end = w_x + c_RECT_W;
    assign w_y_end = w_y + c_RECT_H;
    assign w_h_hit = (w_h >= w_x) && (w_h < w_x_end);
    assign w_v_hit = (w_v >= w_y) && (w_v < w_y_end);

`ifdef DRAW_RECT_BORDER_EN
    // Outer edge: first/last column or first/last line of the rectangle.
    // Only meaningful when qualified by the hit flags in stage 2.
    logic w_edge;
    logic r_s1_edge;

    assign w_edge = (w_h == w_x) || (w_h == w_x_end - 13'd1) ||
                    (w_v == w_y) || (w_v == w_y_end - 13'd1);
`else
    // Border colour has no consumer in this build.
    logic w_unused_border;
    assign w_unused_border = ^BORDER_COLOR;
`endif

    // ------------------------------------------------------------------
    // Stage 1: register timing, background pixel and hit flags
    // ------------------------------------------------------------------
    logic [10:0] r_s1_hcount;
    logic [10:0] r_s1_vcount;
    logic        r_s1_hsync;
    logic        r_s1_vsync;
    logic        r_s1_hblnk;
    logic        r_s1_vblnk;
    logic [11:0] r_s1_rgb;
    logic        r_s1_h_hit;
    logic        r_s1_v_hit;

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_s1_hcount <= 11'd0;
            r_s1_vcount <= 11'd0;
            r_s1_hsync  <= 1'b0;
            r_s1_vsync  <= 1'b0;
            r_s1_hblnk  <= 1'b0;
            r_s1_vblnk  <= 1'b0;
            r_s1_rgb    <= 12'd0;
            r_s1_h_hit  <= 1'b0;
            r_s1_v_hit  <= 1'b0;
`ifdef DRAW_RECT_BORDER_EN
            r_s1_edge   <= 1'b0;
`endif
        end else begin
            r_s1_hcount <= hcount_in;
            r_s1_vcount <= vcount_in;
            r_s1_hsync  <= hsync_in;
            r_s1_vsync  <= vsync_in;
            r_s1_hblnk  <= hblnk_in;
            r_s1_vblnk  <= vblnk_in;
            r_s1_rgb    <= rgb_in;
            r_s1_h_hit  <= w_h_hit;
            r_s1_v_hit  <= w_v_hit;
`ifdef DRAW_RECT_BORDER_EN
            r_s1_edge   <= w_edge;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: pixel select. Blanking wins, which also clips any part of
    // the rectangle lying outside the active area.
    // ------------------------------------------------------------------
    logic [11:0] w_rgb_sel;

    always_comb begin
        w_rgb_sel = r_s1_rgb;
        if (r_s1_hblnk || r_s1_vblnk) begin
            w_rgb_sel = 12'h000;
        end else if (r_s1_h_hit && r_s1_v_hit) begin
`ifdef DRAW_RECT_BORDER_EN
            w_rgb_sel = r_s1_edge ? BORDER_COLOR : RECT_COLOR;
`else
            w_rgb_sel = RECT_COLOR;
`endif
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            hcount_out <= 11'd0;
            vcount_out <= 11'd0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= 12'd0;
        end else begin
            hcount_out <= r_s1_hcount;
            vcount_out <= r_s1_vcount;
            hsync_out  <= r_s1_hsync;
            vsync_out  <= r_s1_vsync;
            hblnk_out  <= r_s1_hblnk;
            vblnk_out  <= r_s1_vblnk;
            rgb_out    <= w_rgb_sel;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_draw_rect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_draw_rect                                                  |
// | Purpose  : Directed self-checking bench for draw_rect (default params).  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_draw_rect;

    logic        pclk = 1'b0;
    logic        rst;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in, xpos, ypos;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    int checks = 0;
    int errors = 0;

    localparam logic [11:0] c_BG   = 12'h0A5;
    localparam logic [11:0] c_RECT = 12'hF00;
    localparam logic [11:0] c_BORD = 12'hFFF;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hb;
        logic        vb;
        logic [11:0] exp;
    } pix_t;

    always #5 pclk = ~pclk;

    draw_rect dut (
        .pclk       (pclk),
        .rst        (rst),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .hblnk_in   (hblnk_in),
        .vblnk_in   (vblnk_in),
        .rgb_in     (rgb_in),
        .xpos       (xpos),
        .ypos       (ypos),
        .hcount_out (hcount_out),
        .vcount_out (vcount_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .hblnk_out  (hblnk_out),
        .vblnk_out  (vblnk_out),
        .rgb_out    (rgb_out)
    );

    // Hold one pixel for two edges; the output then carries that pixel.
    task automatic probe(input logic [10:0] h, input logic [10:0] v,
                         input logic hb, input logic vb, output logic [11:0] px);
        hcount_in = h;
        vcount_in = v;
        hsync_in  = 1'b0;
        vsync_in  = 1'b0;
        hblnk_in  = hb;
        vblnk_in  = vb;
        rgb_in    = c_BG;
        @(posedge pclk);
        @(posedge pclk);
        #1;
        px = rgb_out;
    endtask

    // Produce a vblnk rising edge with the given corner on xpos/ypos.
    task automatic latch(input logic [11:0] x, input logic [11:0] y);
        xpos     = x;
        ypos     = y;
        hblnk_in = 1'b1;
        vblnk_in = 1'b0;
        @(posedge pclk);
        #1;
        vblnk_in = 1'b1;
        @(posedge pclk);
        #1;
        vblnk_in = 1'b0;
        hblnk_in = 1'b0;
    endtask

    task automatic test_reset;
        logic [37:0] got;
        rst       = 1'b1;
        hcount_in = 11'd5;
        vcount_in = 11'd7;
        hsync_in  = 1'b1;
        vsync_in  = 1'b1;
        hblnk_in  = 1'b1;
        vblnk_in  = 1'b1;
        rgb_in    = c_BG;
        xpos      = 12'd100;
        ypos      = 12'd50;
        @(posedge pclk);
        @(posedge pclk);
        #1;
        got = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
        checks++;
        if (got !== 38'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", got, 38'd0);
        end
        rst = 1'b0;
        vblnk_in = 1'b0;
        @(posedge pclk);
        #1;
    endtask

    task automatic test_latency;
        logic [37:0] hist [16];
        logic [37:0] got;
        logic [10:0] h, v;
        logic        hs, vs, hb, vb;
        latch(12'd2047, 12'd2047);
        for (int i = 0; i < 16; i++) begin
            h  = 11'(790 + i);
            v  = 11'(599 + i / 8);
            hs = i[1];
            vs = i[2];
            hb = (h >= 11'd800);
            vb = (v >= 11'd600);
            hcount_in = h;
            vcount_in = v;
            hsync_in  = hs;
            vsync_in  = vs;
            hblnk_in  = hb;
            vblnk_in  = vb;
            rgb_in    = c_BG;
            hist[i] = {h, v, hs, vs, hb, vb, (hb | vb) ? 12'h000 : c_BG};
            @(posedge pclk);
            #1;
            if (i >= 1) begin
                got = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
                checks++;
                if (got !== hist[i-1]) begin
                    errors++;
                    $display("FAIL latency[%0d]: got %h expected %h", i, got, hist[i-1]);
                end
            end
        end
        vblnk_in = 1'b0;
        hblnk_in = 1'b0;
    endtask

    task automatic test_hit_window;
        pix_t tv[8] = '{
            '{11'd100, 11'd50,  1'b0, 1'b0, c_RECT},
            '{11'd147, 11'd113, 1'b0, 1'b0, c_RECT},
            '{11'd100, 11'd113, 1'b0, 1'b0, c_RECT},
            '{11'd99,  11'd50,  1'b0, 1'b0, c_BG},
            '{11'd148, 11'd60,  1'b0, 1'b0, c_BG},
            '{11'd120, 11'd49,  1'b0, 1'b0, c_BG},
            '{11'd120, 11'd114, 1'b0, 1'b0, c_BG},
            '{11'd500, 11'd300, 1'b0, 1'b0, c_BG}
        };
        logic [11:0] px;
        latch(12'd100, 12'd50);
        // A mid-frame change must not disturb this frame.
        xpos = 12'd0;
        ypos = 12'd0;
        foreach (tv[i]) begin
            probe(tv[i].h, tv[i].v, tv[i].hb, tv[i].vb, px);
            checks++;
            if (px !== tv[i].exp) begin
                errors++;
                $display("FAIL hit_window (%0d,%0d): got %h expected %h", tv[i].h, tv[i].v, px, tv[i].exp);
            end
        end
    endtask

    task automatic test_midframe_move;
        pix_t cur[2] = '{
            '{11'd100, 11'd205, 1'b0, 1'b0, c_RECT},
            '{11'd300, 11'd205, 1'b0, 1'b0, c_BG}
        };
        pix_t nxt[4] = '{
            '{11'd300, 11'd160, 1'b0, 1'b0, c_RECT},
            '{11'd347, 11'd160, 1'b0, 1'b0, c_RECT},
            '{11'd100, 11'd160, 1'b0, 1'b0, c_BG},
            '{11'd348, 11'd160, 1'b0, 1'b0, c_BG}
        };
        logic [11:0] px;
        latch(12'd100, 12'd150);
        probe(11'd10, 11'd200, 1'b0, 1'b0, px);
        xpos = 12'd300;
        foreach (cur[i]) begin
            probe(cur[i].h, cur[i].v, cur[i].hb, cur[i].vb, px);
            checks++;
            if (px !== cur[i].exp) begin
                errors++;
                $display("FAIL move_current (%0d,%0d): got %h expected %h", cur[i].h, cur[i].v, px, cur[i].exp);
            end
        end
        latch(12'd300, 12'd150);
        foreach (nxt[i]) begin
            probe(nxt[i].h, nxt[i].v, nxt[i].hb, nxt[i].vb, px);
            checks++;
            if (px !== nxt[i].exp) begin
                errors++;
                $display("FAIL move_next (%0d,%0d): got %h expected %h", nxt[i].h, nxt[i].v, px, nxt[i].exp);
            end
        end
    endtask

    task automatic test_clip;
        pix_t tv[8] = '{
            '{11'd780, 11'd590, 1'b0, 1'b0, c_RECT},
            '{11'd799, 11'd599, 1'b0, 1'b0, c_RECT},
            '{11'd779, 11'd595, 1'b0, 1'b0, c_BG},
            '{11'd785, 11'd589, 1'b0, 1'b0, c_BG},
            '{11'd800, 11'd595, 1'b1, 1'b0, 12'h000},
            '{11'd790, 11'd600, 1'b0, 1'b1, 12'h000},
            '{11'd0,   11'd595, 1'b0, 1'b0, c_BG},
            '{11'd27,  11'd595, 1'b0, 1'b0, c_BG}
        };
        pix_t ev[4] = '{
            '{11'd0,  11'd0,  1'b0, 1'b0, c_RECT},
            '{11'd47, 11'd63, 1'b0, 1'b0, c_RECT},
            '{11'd48, 11'd0,  1'b0, 1'b0, c_BG},
            '{11'd0,  11'd64, 1'b0, 1'b0, c_BG}
        };
        logic [11:0] px;
        latch(12'd780, 12'd590);
        foreach (tv[i]) begin
            probe(tv[i].h, tv[i].v, tv[i].hb, tv[i].vb, px);
            checks++;
            if (px !== tv[i].exp) begin
                errors++;
                $display("FAIL clip (%0d,%0d): got %h expected %h", tv[i].h, tv[i].v, px, tv[i].exp);
            end
        end
        latch(12'd0, 12'd0);
        foreach (ev[i]) begin
            probe(ev[i].h, ev[i].v, ev[i].hb, ev[i].vb, px);
            checks++;
            if (px !== ev[i].exp) begin
                errors++;
                $display("FAIL corner_zero (%0d,%0d): got %h expected %h", ev[i].h, ev[i].v, px, ev[i].exp);
            end
        end
        latch(12'd2047, 12'd2047);
        probe(11'd0, 11'd0, 1'b0, 1'b0, px);
        checks++;
        if (px !== c_BG) begin
            errors++;
            $display("FAIL corner_max_nowrap: got %h expected %h", px, c_BG);
        end
    endtask

    task automatic test_reset_midline;
        logic [37:0] got;
        logic [11:0] px;
        latch(12'd100, 12'd50);
        probe(11'd120, 11'd60, 1'b0, 1'b0, px);
        checks++;
        if (px !== c_RECT) begin
            errors++;
            $display("FAIL pre_reset_hit: got %h expected %h", px, c_RECT);
        end
        hsync_in  = 1'b1;
        vsync_in  = 1'b1;
        vcount_in = 11'd300;
        rgb_in    = c_BG;
        rst       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            hcount_in = 11'(400 + i);
            @(posedge pclk);
            #1;
            got = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
            checks++;
            if (got !== 38'd0) begin
                errors++;
                $display("FAIL in_reset[%0d]: got %h expected %h", i, got, 38'd0);
            end
        end
        rst = 1'b0;
        hcount_in = 11'd403;
        @(posedge pclk);
        #1;
        got = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
        checks++;
        if (got !== 38'd0) begin
            errors++;
            $display("FAIL post_release_1: got %h expected %h", got, 38'd0);
        end
        hcount_in = 11'd404;
        @(posedge pclk);
        #1;
        got = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
        checks++;
        if (got !== {11'd403, 11'd300, 1'b1, 1'b1, 1'b0, 1'b0, c_BG}) begin
            errors++;
            $display("FAIL post_release_2: got %h expected %h", got,
                     {11'd403, 11'd300, 1'b1, 1'b1, 1'b0, 1'b0, c_BG});
        end
        // Shadow corner is back at 0 until the next frame start.
        probe(11'd120, 11'd60, 1'b0, 1'b0, px);
        checks++;
        if (px !== c_BG) begin
            errors++;
            $display("FAIL post_reset_no_rect: got %h expected %h", px, c_BG);
        end
        latch(12'd100, 12'd50);
        probe(11'd120, 11'd60, 1'b0, 1'b0, px);
        checks++;
        if (px !== c_RECT) begin
            errors++;
            $display("FAIL post_reset_relatch: got %h expected %h", px, c_RECT);
        end
    endtask

    task automatic test_border;
`ifdef DRAW_RECT_BORDER_EN
        pix_t tv[4] = '{
            '{11'd100, 11'd60,  1'b0, 1'b0, c_BORD},
            '{11'd147, 11'd113, 1'b0, 1'b0, c_BORD},
            '{11'd120, 11'd50,  1'b0, 1'b0, c_BORD},
            '{11'd120, 11'd80,  1'b0, 1'b0, c_RECT}
        };
`else
        pix_t tv[4] = '{
            '{11'd100, 11'd60,  1'b0, 1'b0, c_RECT},
            '{11'd147, 11'd113, 1'b0, 1'b0, c_RECT},
            '{11'd120, 11'd50,  1'b0, 1'b0, c_RECT},
            '{11'd120, 11'd80,  1'b0, 1'b0, c_RECT}
        };
`endif
        logic [11:0] px;
        latch(12'd100, 12'd50);
        foreach (tv[i]) begin
            probe(tv[i].h, tv[i].v, tv[i].hb, tv[i].vb, px);
            checks++;
            if (px !== tv[i].exp) begin
                errors++;
                $display("FAIL border (%0d,%0d): got %h expected %h", tv[i].h, tv[i].v, px, tv[i].exp);
            end
        end
    endtask

    initial begin
        test_reset;
        test_latency;
        test_hit_window;
        test_midframe_move;
        test_clip;
        test_reset_midline;
        test_border;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/draw_rect.md
DRAW_RECT -- requirements
Module: draw_rect

Interface
REQ-001 Parameter RECT_WIDTH, default 48, rectangle width in pixels (1..2047).
REQ-002 Parameter RECT_HEIGHT, default 64, rectangle height in lines (1..2047).
REQ-003 Parameter RECT_COLOR, default 12'hF00, 4:4:4 RGB fill colour.
REQ-004 Parameter BORDER_COLOR, default 12'hFFF, border colour (used only under REQ-024).
REQ-005 pclk  input  1  pixel clock; the block has one clock, and all state changes on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 hcount_in, vcount_in  input  11 each  horizontal and vertical pixel counts from the timing stage.
REQ-008 hsync_in, vsync_in, hblnk_in, vblnk_in  input  1 each  sync and blanking strobes from the timing stage.
REQ-009 rgb_in  input  12  upstream background pixel.
REQ-010 xpos, ypos  input  12 each  requested top-left corner of the rectangle; asynchronous to the frame.
REQ-011 hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out  output  same widths as inputs  delayed timing.
REQ-012 rgb_out  output  12  composed pixel.

Function
REQ-013 Fixed two-cycle pipeline: every *_out equals its *_in from exactly 2 pclk cycles earlier, and rgb_out is aligned to the same delay.
REQ-014 Frame-start detect: vblnk_prev is a register holding vblnk_in from the previous cycle; frame_start = vblnk_in AND NOT vblnk_prev.
REQ-015 On a frame_start cycle, the shadow registers x_lat and y_lat load xpos and ypos; otherwise they hold.
  - xpos/ypos changes mid-frame never alter the current frame.
REQ-016 Stage 1 registers the hit flags using 13-bit arithmetic, so there is no wrap:
  - h_hit = (hcount_in >= x_lat) AND (hcount_in < x_lat + RECT_WIDTH).
  - v_hit = (vcount_in >= y_lat) AND (vcount_in < y_lat + RECT_HEIGHT).
REQ-017 Stage 1 also registers rgb_in and all timing signals.
REQ-018 Stage 2 selects rgb_out by priority:
  - 12'h000 if stage-1 hblnk or vblnk is set;
  - else RECT_COLOR if h_hit AND v_hit;
  - else the stage-1 rgb.
REQ-019 A rectangle extending past the active area is clipped by the blanking rule; x_lat + RECT_WIDTH > 2047 shall not wrap to the left edge.
REQ-020 If frame_start and a pixel in the rectangle occur on the same cycle, the hit for that cycle uses the old x_lat/y_lat, and the new values take effect from the next cycle.
REQ-021 xpos/ypos values of 0 and of 2047 are legal and shall not produce an X result or a wrapped result.

Reset
REQ-022 While rst=1 on a rising pclk edge, the block clears:
  - all outputs, both pipeline stages, vblnk_prev, x_lat and y_lat to 0.
REQ-023 Reset asserted mid-frame:
  - Outputs are 0 from the first edge with rst=1.
  - After rst deasserts, the first non-reset output appears 2 cycles later.
  - x_lat and y_lat stay 0 until the next frame_start.

Configuration
REQ-024 With macro DRAW_RECT_BORDER_EN defined, a rectangle pixel uses BORDER_COLOR when it lies on the outer edge, and RECT_COLOR otherwise.
  - Outer edge means hcount == x_lat, hcount == x_lat+RECT_WIDTH-1, vcount == y_lat, or vcount == y_lat+RECT_HEIGHT-1.
  - The edge flag is registered in stage 1, so latency is unchanged.
REQ-025 With DRAW_RECT_BORDER_EN undefined, no border logic exists and every rectangle pixel is RECT_COLOR.

Verification
REQ-026 Latency: drive the 800x600 timing stream with rgb_in=12'h0A5 and xpos=ypos=2047 -> *_out equals *_in delayed exactly 2 cycles, and rgb_out=12'h0A5 in active area and 0 in blanking.
REQ-027 Hit window: set xpos=100 and ypos=50 before vblank, using the defaults -> in the next frame, rgb_out=12'hF00 exactly for hcount_out 100..147 and vcount_out 50..113, and rgb_in elsewhere.
REQ-028 Mid-frame move: change xpos to 300 at vcount=200 -> the current frame keeps x=100, and the following frame shows x=300..347.
REQ-029 Clipping: set xpos=780 and ypos=590 -> rectangle visible at hcount 780..799 and vcount 590..599, rgb_out=0 in blanking, and no pixels at hcount 0..27.
REQ-030 Reset mid-line: assert rst for 3 cycles at hcount=400, vcount=300 -> all outputs are 0 during reset, outputs resume 2 cycles after release, and no rectangle appears until after the next frame_start latch.
REQ-031 Border build: define DRAW_RECT_BORDER_EN with xpos=100 and ypos=50 -> pixel (100,60) and pixel (147,113) are 12'hFFF, and pixel (120,80) is 12'hF00.
